// File: rtl/tpu_package.sv
// Shared definitions for the TPU weight path.
//   MUL_SIZE           : systolic array dimension, i.e. rows per weight tile
//   weight_seq_state_t : top-level state of the weight tile sequencer
package tpu_package;

  localparam int MUL_SIZE = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } weight_seq_state_t;

endpackage

// File: rtl/tpu_mod_counter.sv
// Modulo-MOD up counter with synchronous clear.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   en_i    : advance by one, wrapping from MOD-1 back to 0
//   clr_i   : synchronous clear, wins over en_i
//   count_o : current count, 0 .. MOD-1
module tpu_mod_counter #(
  parameter int MOD = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   clr_i,
  output logic [$clog2(MOD)-1:0] count_o
);

  localparam int W = $clog2(MOD);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default assignment first, so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      // Explicit compare-and-reset keeps the wrap correct for non-power-of-two MOD.
      count_d = (count_q == W'(MOD - 1)) ? '0 : count_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/weight_tile_sequencer.sv
// Weight tile sequencer: manages N_BUF weight-buffer slots as a ring,
// streams ROWS rows per tile from the weight FIFO into the write slot and
// hands complete tiles to the compute side in order.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i, num_tiles_i   : start pulse and tile count of the instruction
//   fifo_valid_i           : weight FIFO has a row
//   fifo_ready_o           : a row is accepted this cycle if valid
//   load_weights_o         : row write strobe (valid & ready)
//   load_buf_o, load_row_o : slot and row being written
//   next_weight_tile_i     : compute releases the head tile
//   abort_i                : synchronous flush, highest priority
//   compute_weights_rdy_o  : head slot holds a complete tile
//   compute_buf_o          : head (read) slot
//   tiles_buffered_o       : complete, unreleased tiles
//   busy_o                 : instruction in progress
//   done_o                 : one-cycle pulse after the last release
module weight_tile_sequencer
  import tpu_package::*;
#(
  parameter int ROWS       = MUL_SIZE,
  parameter int N_BUF      = 2,
  parameter int TILE_CNT_W = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [TILE_CNT_W-1:0]        num_tiles_i,
  input  logic                         fifo_valid_i,
  output logic                         fifo_ready_o,
  output logic                         load_weights_o,
  output logic [$clog2(N_BUF)-1:0]     load_buf_o,
  output logic [$clog2(ROWS)-1:0]      load_row_o,
  input  logic                         next_weight_tile_i,
  input  logic                         abort_i,
  output logic                         compute_weights_rdy_o,
  output logic [$clog2(N_BUF)-1:0]     compute_buf_o,
  output logic [$clog2(N_BUF+1)-1:0]   tiles_buffered_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int BUF_W  = $clog2(N_BUF);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int FULL_W = $clog2(N_BUF + 1);

  weight_seq_state_t     state_q;
  logic [TILE_CNT_W-1:0] num_tiles_q;
  logic [TILE_CNT_W-1:0] loaded_cnt_q;
  logic [TILE_CNT_W-1:0] released_cnt_q;
  logic [FULL_W-1:0]     full_cnt_q, full_cnt_d;
  logic                  done_q;

  logic [ROW_W-1:0] row_cnt;
  logic [BUF_W-1:0] wr_ptr;
  logic [BUF_W-1:0] rd_ptr;

  logic start_go;
  logic cnt_clr;
  logic fifo_ready;
  logic handshake;
  logic tile_done;
  logic release_ok;
  logic last_release;

  // A start is only taken from IDLE with a non-empty instruction; abort wins.
  assign start_go   = (state_q == IDLE) && start_i && (num_tiles_i != '0) && !abort_i;
  assign cnt_clr    = abort_i || start_go;

  // Ready is a pure function of registered state, never of fifo_valid_i.
  assign fifo_ready = (state_q == RUN) && (full_cnt_q < FULL_W'(N_BUF))
                      && (loaded_cnt_q < num_tiles_q);
  assign handshake  = fifo_valid_i && fifo_ready;
  assign tile_done  = handshake && (row_cnt == ROW_W'(ROWS - 1));

  // A release with nothing buffered is dropped, not remembered.
  assign release_ok   = (state_q == RUN) && next_weight_tile_i && (full_cnt_q != '0);
  assign last_release = release_ok && ((released_cnt_q + TILE_CNT_W'(1)) == num_tiles_q);

  always_comb begin
    full_cnt_d = full_cnt_q;
    unique case ({tile_done, release_ok})
      2'b10:   full_cnt_d = full_cnt_q + FULL_W'(1);
      2'b01:   full_cnt_d = full_cnt_q - FULL_W'(1);
      default: full_cnt_d = full_cnt_q;  // none, or completion and release together
    endcase
  end

  tpu_mod_counter #(.MOD(ROWS)) u_row_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (handshake),
    .clr_i   (cnt_clr),
    .count_o (row_cnt)
  );

  tpu_mod_counter #(.MOD(N_BUF)) u_wr_ptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (tile_done),
    .clr_i   (cnt_clr),
    .count_o (wr_ptr)
  );

  tpu_mod_counter #(.MOD(N_BUF)) u_rd_ptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (release_ok),
    .clr_i   (cnt_clr),
    .count_o (rd_ptr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      num_tiles_q    <= '0;
      loaded_cnt_q   <= '0;
      released_cnt_q <= '0;
      full_cnt_q     <= '0;
      done_q         <= 1'b0;
    end else if (abort_i) begin
      state_q        <= IDLE;
      num_tiles_q    <= '0;
      loaded_cnt_q   <= '0;
      released_cnt_q <= '0;
      full_cnt_q     <= '0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_go) begin
            state_q        <= RUN;
            num_tiles_q    <= num_tiles_i;
            loaded_cnt_q   <= '0;
            released_cnt_q <= '0;
            full_cnt_q     <= '0;
          end
        end
        RUN: begin
          full_cnt_q <= full_cnt_d;
          if (tile_done) begin
            loaded_cnt_q <= loaded_cnt_q + TILE_CNT_W'(1);
          end
          if (release_ok) begin
            released_cnt_q <= released_cnt_q + TILE_CNT_W'(1);
          end
          if (last_release) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_ready_o          = fifo_ready;
  assign load_weights_o        = handshake;
  assign load_buf_o            = wr_ptr;
  assign load_row_o            = row_cnt;
  assign compute_weights_rdy_o = (full_cnt_q != '0);
  assign compute_buf_o         = rd_ptr;
  assign tiles_buffered_o      = full_cnt_q;
  assign busy_o                = (state_q == RUN);
  assign done_o                = done_q;

endmodule

// File: tb/tb_weight_tile_sequencer.sv
// Bench for weight_tile_sequencer. Two instances (N_BUF=2 and N_BUF=3, ROWS=4)
// share the same stimulus; each is compared every cycle against its own
// tile-level reference model.
module tb_weight_tile_sequencer;

  localparam int ROWS = 4;
  localparam int TW   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [TW-1:0] num_tiles;
  logic          valid;
  logic          next_tile;
  logic          abort;

  always #5 clk = ~clk;

  // N_BUF = 2 instance
  logic       rdy2, lw2, crdy2, busy2, done2;
  logic [0:0] lbuf2, cbuf2;
  logic [1:0] lrow2, tbuf2;

  // N_BUF = 3 instance
  logic       rdy3, lw3, crdy3, busy3, done3;
  logic [1:0] lbuf3, cbuf3;
  logic [1:0] lrow3, tbuf3;

  weight_tile_sequencer #(.ROWS(ROWS), .N_BUF(2), .TILE_CNT_W(TW)) dut2 (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .start_i               (start),
    .num_tiles_i           (num_tiles),
    .fifo_valid_i          (valid),
    .fifo_ready_o          (rdy2),
    .load_weights_o        (lw2),
    .load_buf_o            (lbuf2),
    .load_row_o            (lrow2),
    .next_weight_tile_i    (next_tile),
    .abort_i               (abort),
    .compute_weights_rdy_o (crdy2),
    .compute_buf_o         (cbuf2),
    .tiles_buffered_o      (tbuf2),
    .busy_o                (busy2),
    .done_o                (done2)
  );

  weight_tile_sequencer #(.ROWS(ROWS), .N_BUF(3), .TILE_CNT_W(TW)) dut3 (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .start_i               (start),
    .num_tiles_i           (num_tiles),
    .fifo_valid_i          (valid),
    .fifo_ready_o          (rdy3),
    .load_weights_o        (lw3),
    .load_buf_o            (lbuf3),
    .load_row_o            (lrow3),
    .next_weight_tile_i    (next_tile),
    .abort_i               (abort),
    .compute_weights_rdy_o (crdy3),
    .compute_buf_o         (cbuf3),
    .tiles_buffered_o      (tbuf3),
    .busy_o                (busy3),
    .done_o                (done3)
  );

  // Tile-level reference model: slots as plain integers taken modulo nbuf.
  typedef struct {
    bit run;
    int ntiles;
    int loaded;
    int released;
    int row;
    int wslot;
    int rslot;
    int buffered;
    bit done;
  } model_t;

  model_t m2, m3;
  int n_total = 0;
  int n_bad   = 0;

  function automatic model_t model_clear();
    model_t m;
    m.run = 0; m.ntiles = 0; m.loaded = 0; m.released = 0; m.row = 0;
    m.wslot = 0; m.rslot = 0; m.buffered = 0; m.done = 0;
    return m;
  endfunction

  function automatic bit model_ready(model_t m, int nbuf);
    return m.run && (m.buffered < nbuf) && (m.loaded < m.ntiles);
  endfunction

  function automatic model_t model_step(model_t m, int nbuf, bit rn, bit s, int nt,
                                        bit v, bit nx, bit ab);
    model_t n;
    bit     take_row;
    bit     take_rel;
    n      = m;
    n.done = 0;
    if (!rn || ab) return model_clear();
    if (!m.run) begin
      if (s && nt != 0) begin
        n        = model_clear();
        n.run    = 1;
        n.ntiles = nt;
      end
      return n;
    end
    take_row = v && model_ready(m, nbuf);
    take_rel = nx && (m.buffered > 0);
    if (take_row) begin
      n.row = m.row + 1;
      if (n.row == ROWS) begin
        n.row      = 0;
        n.wslot    = (m.wslot + 1) % nbuf;
        n.loaded   = m.loaded + 1;
        n.buffered = n.buffered + 1;
      end
    end
    if (take_rel) begin
      n.rslot    = (m.rslot + 1) % nbuf;
      n.released = m.released + 1;
      n.buffered = n.buffered - 1;
      if (n.released == m.ntiles) begin
        n.run  = 0;
        n.done = 1;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input string name, input model_t m, input int nbuf,
                           input int rdy, input int lw, input int lbuf, input int lrow,
                           input int crdy, input int cbuf, input int tbuf,
                           input int busy, input int done);
    int r;
    r = int'(model_ready(m, nbuf));
    check({name, ".fifo_ready"},     rdy,  r);
    check({name, ".load_weights"},   lw,   int'(valid) & r);
    check({name, ".load_buf"},       lbuf, m.wslot);
    check({name, ".load_row"},       lrow, m.row);
    check({name, ".compute_rdy"},    crdy, int'(m.buffered != 0));
    check({name, ".compute_buf"},    cbuf, m.rslot);
    check({name, ".tiles_buffered"}, tbuf, m.buffered);
    check({name, ".busy"},           busy, int'(m.run));
    check({name, ".done"},           done, int'(m.done));
  endtask

  // One clock: compare at the falling edge, then advance both models at the rising edge.
  task automatic tick();
    @(negedge clk);
    check_dut("nbuf2", m2, 2, int'(rdy2), int'(lw2), int'(lbuf2), int'(lrow2),
              int'(crdy2), int'(cbuf2), int'(tbuf2), int'(busy2), int'(done2));
    check_dut("nbuf3", m3, 3, int'(rdy3), int'(lw3), int'(lbuf3), int'(lrow3),
              int'(crdy3), int'(cbuf3), int'(tbuf3), int'(busy3), int'(done3));
    @(posedge clk);
    m2 = model_step(m2, 2, rst_n, start, int'(num_tiles), valid, next_tile, abort);
    m3 = model_step(m3, 3, rst_n, start, int'(num_tiles), valid, next_tile, abort);
    #1;
  endtask

  task automatic drive(input bit s, input int nt, input bit v, input bit nx, input bit ab);
    start     = s;
    num_tiles = TW'(nt);
    valid     = v;
    next_tile = nx;
    abort     = ab;
    tick();
  endtask

  task automatic flush();
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; num_tiles = '0; valid = 0; next_tile = 0; abort = 0;
    m2 = model_clear();
    m3 = model_clear();
    tick();
    tick();
    #2 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);

    // Fill and hold: 3 tiles, valid held, no release.
    drive(1, 3, 1, 0, 0);
    repeat (14) drive(0, 0, 1, 0, 0);
    // Releases, including overlap with loading the third tile.
    repeat (12) drive(0, 0, 1, 1, 0);
    repeat (3) drive(0, 0, 0, 0, 0);

    // Concurrent completion and release on the 8th handshake.
    drive(1, 3, 0, 0, 0);
    for (int k = 1; k <= 8; k++) drive(0, 0, 1, (k == 8), 0);
    repeat (3) drive(0, 0, 1, 0, 0);
    flush();

    // Zero-tile start ignored, then gapped valid.
    drive(1, 0, 1, 0, 0);
    drive(1, 4, 0, 0, 0);
    drive(1, 2, 0, 0, 0);  // start while running, ignored
    for (int k = 0; k < 32; k++) drive(0, 0, k[0], 0, 0);
    flush();

    // Spurious release, then three releases completing the instruction.
    drive(1, 3, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    repeat (8) drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    repeat (4) drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0);

    // Abort at row 2 of tile 1, then a fresh start.
    drive(1, 3, 0, 0, 0);
    repeat (6) drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(1, 2, 1, 0, 0);
    repeat (3) drive(0, 0, 1, 0, 0);

    // Asynchronous reset mid-row, between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("async.busy2",  int'(busy2),  0);
    check("async.busy3",  int'(busy3),  0);
    check("async.row2",   int'(lrow2),  0);
    check("async.row3",   int'(lrow3),  0);
    check("async.lbuf2",  int'(lbuf2),  0);
    check("async.tbuf2",  int'(tbuf2),  0);
    check("async.rdy2",   int'(rdy2),   0);
    check("async.lw2",    int'(lw2),    0);
    m2 = model_clear();
    m3 = model_clear();
    tick();
    #2 rst_n = 1'b1;
    repeat (3) drive(0, 0, 1, 1, 0);

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      drive($urandom_range(0, 11) == 0, int'($urandom_range(0, 6)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 249) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/weight_tile_sequencer.md
# weight_tile_sequencer

Parametrised successor to the single-tile weight loader. It tracks `N_BUF` weight-tile slots in the systolic array's weight buffer as a ring, and streams `ROWS` rows per tile from the weight FIFO under a valid/ready handshake. It hands complete tiles to the compute side in order and releases each slot when compute requests the next tile. It sits between the weight FIFO, the weight-buffer write port and the MAC-array compute controller, and retires a whole multi-tile instruction.

## Interface
- `ROWS`, default `MUL_SIZE`: rows per weight tile; ≥2.
- `N_BUF`, default 2: tile slots; ≥2.
- `TILE_CNT_W`, default 16: width of the tile count.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `start_i` in 1: one-cycle pulse; latches `num_tiles_i`.
- `num_tiles_i` in `TILE_CNT_W`: tiles in this instruction.
- `fifo_valid_i` in 1: weight FIFO has a row.
- `fifo_ready_o` out 1: sequencer accepts a row this cycle.
- `load_weights_o` out 1: row write strobe, equal to `fifo_valid_i & fifo_ready_o`.
- `load_buf_o` out `$clog2(N_BUF)`: slot being written.
- `load_row_o` out `$clog2(ROWS)`: row being written.
- `next_weight_tile_i` in 1: compute releases the head tile.
- `abort_i` in 1: synchronous flush.
- `compute_weights_rdy_o` out 1: head slot holds a complete tile.
- `compute_buf_o` out `$clog2(N_BUF)`: head (read) slot.
- `tiles_buffered_o` out `$clog2(N_BUF+1)`: count of complete, unreleased tiles.
- `busy_o` out 1: state is not IDLE.
- `done_o` out 1: one-cycle pulse when the last tile is released.

## Operation
- States: IDLE, RUN.
- IDLE → RUN on `start_i` with `num_tiles_i != 0`. This clears `wr_ptr`, `rd_ptr`, `row_cnt`, `full_cnt`, `loaded_cnt` and `released_cnt`.
- `start_i` with `num_tiles_i == 0` is ignored.
- `start_i` while in RUN is ignored.
- `fifo_ready_o = RUN & (full_cnt < N_BUF) & (loaded_cnt < num_tiles_q)`. It is decoded from registers only and never depends on `fifo_valid_i`.
- Each handshake increments `row_cnt`.
- On a handshake at `row_cnt == ROWS-1`:
  - `row_cnt` wraps to 0.
  - `wr_ptr` advances modulo `N_BUF`.
  - `full_cnt` and `loaded_cnt` each increment.
- `next_weight_tile_i` with `full_cnt != 0`: `rd_ptr` advances modulo `N_BUF`, `full_cnt` decrements, `released_cnt` increments.
- `next_weight_tile_i` with `full_cnt == 0` has no effect. It is counted neither now nor later.
- Tile completion and release in the same cycle: both pointers advance and `full_cnt` is unchanged.
- When `released_cnt` reaches `num_tiles_q` (on the release edge): pulse `done_o` for one cycle and go to IDLE.
- `abort_i` has priority over every other input. In any state it forces IDLE and clears all counters and pointers. No `done_o` pulse is produced.
- `compute_weights_rdy_o = (full_cnt != 0)`.
- `tiles_buffered_o = full_cnt`.
- `compute_buf_o = rd_ptr`, `load_buf_o = wr_ptr`, `load_row_o = row_cnt`.
- Pointer wrap must be correct for non-power-of-two `N_BUF`: compare with `N_BUF-1`, then reset to 0.

## Timing
- Reset: every register clears immediately on `rst_ni` low, independent of the clock. All outputs read 0 and the state is IDLE.
- The first row can be accepted in the cycle after `start_i`.
- With `fifo_valid_i` held high, a tile takes exactly `ROWS` cycles. There is no bubble between tiles while a slot is free.
- `compute_weights_rdy_o` rises in the cycle after the last-row handshake. There is no combinational bypass.
- A release frees its slot for loading in the next cycle.
- A gap in `fifo_valid_i` stalls `row_cnt` and causes no other state change.
- `done_o` is asserted in the cycle after the final release. `busy_o` falls in that same cycle.

## Structure
- Shared package `tpu_package`:
  - `MUL_SIZE`.
  - `weight_seq_state_t` enum: IDLE, RUN.
- One sub-module, `tpu_mod_counter`: parameter `MOD`, inputs `en`/`clr`, output count. It is instantiated three times: `row_cnt` (MOD=`ROWS`), `wr_ptr` and `rd_ptr` (MOD=`N_BUF`).
- Expected RTL size: about 200 lines.

## Test plan
All scenarios use `ROWS=4`, `N_BUF=2` unless stated.

- **Fill and hold:** `start_i` with `num_tiles_i=3`, valid held high, no release → 8 handshakes. Then `fifo_ready_o` stays 0, `tiles_buffered_o=2`, and `compute_weights_rdy_o` is first high in the cycle after the 4th handshake.
- **Concurrent complete/release:** one tile buffered, `next_weight_tile_i` pulsed in the cycle of a last-row handshake → `tiles_buffered_o` stays 1, and both `compute_buf_o` and `load_buf_o` advance.
- **Gapped valid, non-power-of-two:** valid toggling every other cycle, `N_BUF=3` → `load_row_o` sequence 0,1,2,3 with stalls held, and `load_buf_o` sequence 0,1,2,0.
- **Spurious release and completion:** release pulsed while `tiles_buffered_o=0` → ignored. Then 3 valid releases → single-cycle `done_o` pulse and IDLE.
- **Abort:** `abort_i` at row 2 of tile 1 → next cycle all counters 0, no `done_o`, and a fresh `start_i` loads slot 0 row 0.
- **Async reset:** `rst_ni` low mid-row, between clock edges → outputs go to 0 before the next edge and remain in IDLE after release.
